// File: rtl/instruction_assembler_pkg.sv
// Shared definitions for the instruction assembler.
//   state_e     : fill-sequencer state encoding
//   MODE_DIRECT : Mode value selecting direct indexed byte writes
//   MODE_SEQ    : Mode value selecting handshake-driven sequential fill
package instruction_assembler_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StFill = 2'd1,
    StFull = 2'd2
  } state_e;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SEQ    = 1'b1;

endpackage

// File: rtl/instruction_assembler_byte_lane_reg.sv
// One byte lane of the assembled instruction word.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset, clears the lane
//   en  : load enable
//   d   : byte to load
//   q   : stored byte
module instruction_assembler_byte_lane_reg #(
  parameter int unsigned BYTE_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [BYTE_W-1:0] d,
  output logic [BYTE_W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/instruction_assembler.sv
// Assembles an instruction word of NUM_BYTES bytes from a byte-wide memory bus.
//   Clock, Reset : rising-edge clock, asynchronous active-high reset
//   I            : byte from the memory bus
//   Mode         : 0 = direct indexed write, 1 = sequential handshake fill
//   Write, Sel   : direct-mode write strobe and byte index (0 = LSB)
//   InValid      : sequential-mode byte offered
//   InReady      : sequential-mode byte can be accepted
//   Take         : decoder consumes the completed word
//   Flush        : synchronous abort of a sequential fill
//   IROut        : assembled instruction word
//   IRValid      : complete word held (sequential mode)
//   ByteCount    : next byte index in sequential fill
module instruction_assembler
  import instruction_assembler_pkg::*;
#(
  parameter int unsigned BYTE_W    = 8,
  parameter int unsigned NUM_BYTES = 2,
  parameter int unsigned SEL_W     = $clog2(NUM_BYTES)
) (
  input  logic                        Clock,
  input  logic                        Reset,
  input  logic [BYTE_W-1:0]           I,
  input  logic                        Mode,
  input  logic                        Write,
  input  logic [SEL_W-1:0]            Sel,
  input  logic                        InValid,
  output logic                        InReady,
  input  logic                        Take,
  input  logic                        Flush,
  output logic [BYTE_W*NUM_BYTES-1:0] IROut,
  output logic                        IRValid,
  output logic [SEL_W-1:0]            ByteCount
);

  localparam logic [SEL_W-1:0] LastIdx = SEL_W'(NUM_BYTES - 1);

  state_e                 state_q, state_d;
  logic   [SEL_W-1:0]     count_q, count_d;
  logic                   accept;
  logic                   direct_wr;
  logic   [NUM_BYTES-1:0] lane_en;

  // Flush blocks acceptance so it wins over a concurrent handshake.
  assign InReady   = (Mode == MODE_SEQ) && (state_q != StFull) && !Flush;
  assign accept    = InReady && InValid;
  // Out-of-range indices (possible when NUM_BYTES is not a power of two) are dropped.
  assign direct_wr = (Mode == MODE_DIRECT) && Write && (32'(Sel) < NUM_BYTES);

  assign IRValid   = (state_q == StFull);
  assign ByteCount = count_q;

  for (genvar g = 0; g < NUM_BYTES; g++) begin : g_lane
    assign lane_en[g] = (direct_wr && (Sel == SEL_W'(g))) ||
                        (accept && (count_q == SEL_W'(g)));

    instruction_assembler_byte_lane_reg #(
      .BYTE_W(BYTE_W)
    ) u_lane (
      .clk(Clock),
      .rst(Reset),
      .en (lane_en[g]),
      .d  (I),
      .q  (IROut[g*BYTE_W +: BYTE_W])
    );
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (Flush || (Mode == MODE_DIRECT)) begin
      // Flush, or leaving sequential mode, abandons any partial/complete fill.
      state_d = StIdle;
      count_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            state_d = StFill;
            count_d = SEL_W'(1);
          end
        end
        StFill: begin
          if (accept) begin
            if (count_q == LastIdx) begin
              state_d = StFull;
              count_d = '0;
            end else begin
              count_d = count_q + 1'b1;
            end
          end
        end
        StFull: begin
          if (Take) begin
            state_d = StIdle;
          end
        end
        default: begin
          state_d = StIdle;
          count_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= StIdle;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

endmodule
